ps2_key_pacer: RTL

Paces PS/2 key events between the `hps_io` `ps2_key` bus and the Oric core keyboard inputs (`key_strobe`, `key_pressed`, `key_extended`, `key_code`).

- Every toggle of `ps2_key[10]` is captured into a small FIFO.
- Events are replayed one at a time, with a guaranteed minimum gap between them.
- This lets the Oric ROM's keyboard matrix scan see every press before its release, even when the host delivers press and release back to back.
- It sits directly upstream of the Oric core, replacing the bare toggle-edge strobe.

---
 rtl/ps2_pacer_pkg.sv | 25 ++
 rtl/ps2_pacer_fifo.sv | 62 ++++++
 rtl/ps2_key_pacer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ps2_pacer_pkg.sv
// ============================================================================
// Module   : ps2_pacer_pkg
// Brief    : Shared types for the PS/2 key event pacer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ps2_pacer_pkg;

    localparam int KEY_EVT_W = 10;

    typedef struct packed {
        logic       pressed;
        logic       extended;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } pacer_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_pacer_fifo.sv
// ============================================================================
// Module   : ps2_pacer_fifo
// Brief    : Synchronous FIFO of key events; flush empties it in one cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_pacer_fifo
    import ps2_pacer_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  key_evt_t               din,
    output key_evt_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    key_evt_t      r_mem [DEPTH];
    logic          w_do_push;
    logic          w_do_pop;

    assign level = r_wr_ptr - r_rd_ptr;
    assign full  = (level == (c_AW + 1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = r_mem[r_rd_ptr[c_AW-1:0]];

    // A push into a full queue is still accepted when a pop frees a slot on the same edge.
    assign w_do_pop  = pop & ~empty & ~flush;
    assign w_do_push = push & ~flush & (~full | w_do_pop);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_pacer.sv
// ============================================================================
// Module   : ps2_key_pacer
// Brief    : Queues PS/2 key toggles and replays them with a minimum spacing.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_pacer
    import ps2_pacer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 480000
)
(
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [10:0]            ps2_key,
    input  logic                   flush,
    output logic                   key_strobe,
    output logic                   key_pressed,
    output logic                   key_extended,
    output logic [7:0]             key_code,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   busy
);

    localparam int              c_CW       = $clog2(HOLD_CYCLES);
    localparam logic [c_CW-1:0] c_GAP_LOAD = c_CW'(HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST = c_CW'(1);

    logic         r_primed;
    logic         r_prev_tgl;
    logic         r_strobe;
    logic         r_overflow;
    key_evt_t     r_evt;
    logic [c_CW-1:0] r_gap_cnt;
    logic [c_CW-1:0] w_gap_nxt;
    pacer_state_t r_state;
    pacer_state_t w_state_nxt;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    key_evt_t     w_evt_in;
    key_evt_t     w_head;

    assign w_evt_in = ps2_key[KEY_EVT_W-1:0];
    assign w_push   = r_primed & (ps2_key[10] ^ r_prev_tgl);

    ps2_pacer_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (flush),
        .din     (w_evt_in),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // Leaving GAP on the edge the counter hits zero makes strobes exactly HOLD_CYCLES apart.
    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap_cnt;
        w_pop       = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_gap_nxt   = c_GAP_LOAD;
                        w_state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    w_gap_nxt = r_gap_cnt - c_GAP_LAST;
                    if (r_gap_cnt == c_GAP_LAST) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_primed   <= 1'b0;
            r_prev_tgl <= 1'b0;
            r_strobe   <= 1'b0;
            r_overflow <= 1'b0;
            r_evt      <= '0;
        end else begin
            r_primed   <= 1'b1;
            r_prev_tgl <= ps2_key[10];
            r_strobe   <= w_pop;
            if (w_pop) r_evt <= w_head;
            if (flush) r_overflow <= 1'b0;
            else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    assign key_strobe   = r_strobe;
    assign key_pressed  = r_evt.pressed;
    assign key_extended = r_evt.extended;
    assign key_code     = r_evt.code;
    assign overflow     = r_overflow;
    assign busy         = (r_state == ST_GAP) | (level != '0);

endmodule

`default_nettype wire
